// File: rtl/pipeline_stall_if.sv
// Handshake bundle between the hazard/branch/mul-div logic and the pipeline stall controller.
interface pipeline_stall_if;
  logic        hazard_req;
  logic [1:0]  hazard_cycles;
  logic        branch_taken;
  logic        md_start;
  logic        md_done;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        HazardMux;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        md_timeout;
  logic [15:0] stall_count;

  modport master (
    output hazard_req, hazard_cycles, branch_taken, md_start, md_done,
    input  PCWrite, IFIDWrite, HazardMux, IFIDFlush, IDEXFlush, md_timeout, stall_count
  );

  modport slave (
    input  hazard_req, hazard_cycles, branch_taken, md_start, md_done,
    output PCWrite, IFIDWrite, HazardMux, IFIDFlush, IDEXFlush, md_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: hazard bubbles, branch flushes, mul/div wait with watchdog.
// Optional stall statistics counter enabled by defining PIPELINE_STALL_STATS_EN.
module pipeline_stall_ctrl (
  input  logic             clk,
  input  logic             rst,
  pipeline_stall_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_MDWAIT = 2'd2
  } state_t;

  localparam logic [5:0] WD_LAST = 6'd62;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  wd_q, wd_d;
  logic [1:0]  hz_n_s;

  logic        pc_write_s;
  logic        ifid_write_s;
  logic        hazard_mux_s;
  logic        ifid_flush_s;
  logic        idex_flush_s;
  logic        md_timeout_s;

  // State, bubble counter and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      wd_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  // A requested bubble count of zero still costs one bubble.
  always_comb begin
    if (bus.hazard_cycles == 2'd0) begin
      hz_n_s = 2'd1;
    end else begin
      hz_n_s = bus.hazard_cycles;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      ST_RUN: begin
        if (bus.branch_taken) begin
          state_d = ST_RUN;
        end else if (bus.md_start) begin
          wd_d    = 6'd0;
          state_d = ST_MDWAIT;
        end else if (bus.hazard_req) begin
          if (hz_n_s > 2'd1) begin
            cnt_d   = hz_n_s - 2'd1;
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (bus.branch_taken) begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end else if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - 2'd1;
          state_d = ST_STALL;
        end
      end
      ST_MDWAIT: begin
        if (bus.md_done) begin
          state_d = ST_RUN;
        end else if (wd_q == WD_LAST) begin
          wd_d    = wd_q + 6'd1;
          state_d = ST_RUN;
        end else begin
          wd_d    = wd_q + 6'd1;
          state_d = ST_MDWAIT;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        wd_d    = 6'd0;
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode; stall outputs are the safe default, flushes only with PCWrite=1.
  always_comb begin
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    hazard_mux_s = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    md_timeout_s = 1'b0;
    if (rst) begin
      pc_write_s = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.branch_taken) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            hazard_mux_s = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (bus.md_start || bus.hazard_req) begin
            pc_write_s = 1'b0;
          end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            hazard_mux_s = 1'b0;
          end
        end
        ST_STALL: begin
          if (bus.branch_taken) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            hazard_mux_s = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            pc_write_s = 1'b0;
          end
        end
        ST_MDWAIT: begin
          if (bus.md_done) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            hazard_mux_s = 1'b0;
          end else if (wd_q == WD_LAST) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            hazard_mux_s = 1'b0;
            md_timeout_s = 1'b1;
          end else begin
            pc_write_s = 1'b0;
          end
        end
        default: begin
          pc_write_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.IFIDWrite  = ifid_write_s;
  assign bus.HazardMux  = hazard_mux_s;
  assign bus.IFIDFlush  = ifid_flush_s;
  assign bus.IDEXFlush  = idex_flush_s;
  assign bus.md_timeout = md_timeout_s;

`ifdef PIPELINE_STALL_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    if (!pc_write_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 16'h0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port hazard_req, input, 1, data hazard flagged by hazard detection for the instruction in IF/ID.
REQ-004 SHALL have port hazard_cycles, input, 2, bubble count requested with hazard_req; 0 treated as 1.
REQ-005 SHALL have port branch_taken, input, 1, taken branch resolved in EX this cycle.
REQ-006 SHALL have port md_start, input, 1, multi-cycle mul/div launched from EX.
REQ-007 SHALL have port md_done, input, 1, mul/div result ready.
REQ-008 SHALL have port PCWrite, output, 1, PC update enable.
REQ-009 SHALL have port IFIDWrite, output, 1, IF/ID register write enable.
REQ-010 SHALL have port HazardMux, output, 1, 1 = zero ID/EX control (bubble).
REQ-011 SHALL have port IFIDFlush, output, 1, clear IF/ID.
REQ-012 SHALL have port IDEXFlush, output, 1, clear ID/EX.
REQ-013 SHALL have port md_timeout, output, 1, one-cycle pulse on mul/div watchdog expiry.
REQ-014 SHALL have port stall_count, output, 16, stall statistics (see Configuration).

Function
REQ-015 SHALL implement FSM states RUN, STALL, MDWAIT; "stall outputs" = PCWrite=0, IFIDWrite=0, HazardMux=1, flushes=0; "run outputs" = PCWrite=1, IFIDWrite=1, HazardMux=0, flushes=0.
REQ-016 SHALL evaluate priority each cycle in RUN: branch_taken > md_start > hazard_req > idle.
REQ-017 SHALL, in RUN with branch_taken=1, drive PCWrite=1, IFIDWrite=1, HazardMux=0, IFIDFlush=1, IDEXFlush=1 combinationally that cycle; next state RUN.
REQ-018 SHALL, in RUN with hazard_req=1 (no branch, no md_start), drive stall outputs that same cycle (zero latency); N=hazard_cycles (0->1); if N>1 load cnt=N-1 and go STALL, else stay RUN.
REQ-019 SHALL, in STALL, drive stall outputs, decrement cnt each cycle, return to RUN after the cycle with cnt==1; total stall = exactly N consecutive cycles.
REQ-020 SHALL, in STALL with branch_taken=1, abort the stall: drive the REQ-017 flush outputs that cycle, clear cnt, go RUN.
REQ-021 SHALL ignore hazard_req and md_start while in STALL.
REQ-022 SHALL, in RUN with md_start=1 (no branch), drive stall outputs that cycle, clear 6-bit watchdog, go MDWAIT.
REQ-023 SHALL, in MDWAIT, drive stall outputs while md_done=0; the cycle md_done=1 drive run outputs and go RUN.
REQ-024 SHALL ignore branch_taken, hazard_req and md_start in MDWAIT.
REQ-025 SHALL increment watchdog each MDWAIT cycle with md_done=0; on the 63rd such cycle pulse md_timeout=1 with run outputs and go RUN; md_done on that same cycle wins (no timeout pulse).
REQ-026 SHALL never assert IFIDFlush or IDEXFlush simultaneously with PCWrite=0.

Reset
REQ-027 SHALL, while rst=1, drive PCWrite=0, IFIDWrite=0, HazardMux=1, IFIDFlush=0, IDEXFlush=0, md_timeout=0, ignoring all other inputs.
REQ-028 SHALL on a clock edge with rst=1 set state=RUN, cnt=0, watchdog=0, stall_count=0, including mid-STALL or mid-MDWAIT.

Configuration
REQ-029 SHALL, with macro PIPELINE_STALL_STATS_EN defined, increment stall_count by 1 on each non-reset cycle where PCWrite=0, saturating at 16'hFFFF.
REQ-030 SHALL, without PIPELINE_STALL_STATS_EN, keep the stall_count port and tie it to 16'h0000 with no counter logic.

Verification
REQ-031 SHALL cover: rst 1 cycle, then hazard_req=1, hazard_cycles=2 for 1 cycle -> PCWrite=0 for exactly 2 cycles, then 1.
REQ-032 SHALL cover: hazard_req=1, hazard_cycles=3; branch_taken=1 on 2nd stall cycle -> that cycle IFIDFlush=IDEXFlush=1, PCWrite=1; next cycle run outputs.
REQ-033 SHALL cover: hazard_req=1, md_start=1, branch_taken=1 same RUN cycle -> flush outputs only, state stays RUN.
REQ-034 SHALL cover: md_start, md_done after 5 cycles -> PCWrite=0 for 5 cycles, 1 on md_done cycle; md_timeout never 1.
REQ-035 SHALL cover: md_start, md_done held 0 -> md_timeout pulses exactly once on 63rd MDWAIT cycle; with stats enabled stall_count=63 after it.
REQ-036 SHALL cover: rst=1 mid-MDWAIT -> next cycle after release run outputs, stall_count=0.
